// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with programmable wait states,
// LR/SC reservation tracking and a registered one-cycle acknowledge.
module dmem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_bus_we,
  input  logic [1:0]  i_bus_size,
  input  logic [31:0] i_bus_addr,
  input  logic [31:0] i_bus_wdata,
  input  logic        i_bus_atomic,
  input  logic        i_bus_sc,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_hit,
  output logic        o_bus_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN = 32'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0] cnt_q;

  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_atomic;
  logic        req_sc;

  logic [31:0] mem [MEM_WORDS];

  logic          resv_q;
  logic [AW-1:0] resv_idx_q;

  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] idx;
  logic        bad;
  logic        accept;
  logic        access;
  logic        sc_ok;
  logic        mem_we;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [31:0] rsp_data;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (i_bus_en) state_d = WAIT;
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign accept = (state_q == IDLE) && i_bus_en;
  assign access = (state_q == WAIT) && (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CW'(LATENCY - 1);
    end else if (state_q == WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Request fields are frozen at accept; later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (accept && !i_rst) begin
      req_we     <= i_bus_we;
      req_size   <= i_bus_size;
      req_addr   <= i_bus_addr;
      req_wdata  <= i_bus_wdata;
      req_atomic <= i_bus_atomic;
      req_sc     <= i_bus_sc;
    end
  end

  // Subtraction wraps addresses below the base into the out-of-range side.
  assign off      = req_addr - BASE_ADDR;
  assign in_range = off < SPAN;
  assign idx      = off[AW+1:2];

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (req_size == 2'b11):                       bad = 1'b1;
      (req_size == 2'b01 && req_addr[0]):        bad = 1'b1;
      (req_size == 2'b10 && req_addr[1:0] != 2'b00): bad = 1'b1;
      default:                                   bad = 1'b0;
    endcase
    if (!in_range) bad = 1'b1;
    if (req_atomic && req_size != 2'b10) bad = 1'b1;
  end

  assign sc_ok = resv_q && (resv_idx_q == idx);

  assign mem_we = access && !i_rst && !bad &&
                  (req_atomic ? (req_sc && sc_ok) : req_we);

  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    unique case (req_size)
      2'b00: begin
        be = 4'b0001 << req_addr[1:0];
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = req_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  always_comb begin
    rsp_data = '0;
    if (bad) begin
      rsp_data = '0;
    end else if (req_atomic && req_sc) begin
      rsp_data = sc_ok ? 32'd0 : 32'd1;
    end else if (req_atomic || !req_we) begin
      rsp_data = mem[idx];
    end
  end

  // Any SC drops the reservation; a plain store only when it hits the word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resv_q     <= 1'b0;
      resv_idx_q <= '0;
    end else if (access && !bad) begin
      if (req_atomic && !req_sc) begin
        resv_q     <= 1'b1;
        resv_idx_q <= idx;
      end else if (req_atomic && req_sc) begin
        resv_q <= 1'b0;
      end else if (req_we && resv_idx_q == idx) begin
        resv_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_bus_hit   <= 1'b0;
      o_bus_err   <= 1'b0;
      o_bus_rdata <= '0;
    end else begin
      o_bus_hit   <= 1'b0;
      o_bus_err   <= 1'b0;
      o_bus_rdata <= '0;
      if (access) begin
        o_bus_hit   <= 1'b1;
        o_bus_err   <= bad;
        o_bus_rdata <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder at LATENCY 1, 2 and 5.
module tb_dmem_responder;

  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_1000;
  localparam logic [31:0] B2 = 32'h2000_0000;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        atomic;
  logic        sc;
  logic [31:0] rd [3];
  logic [2:0]  hit;
  logic [2:0]  err;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(16), .BASE_ADDR(B0), .LATENCY(1)) u_l1 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[0]), .i_bus_we(we),
    .i_bus_size(size), .i_bus_addr(addr), .i_bus_wdata(wdata),
    .i_bus_atomic(atomic), .i_bus_sc(sc),
    .o_bus_rdata(rd[0]), .o_bus_hit(hit[0]), .o_bus_err(err[0])
  );

  dmem_responder #(.MEM_WORDS(256), .BASE_ADDR(B1), .LATENCY(2)) u_l2 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[1]), .i_bus_we(we),
    .i_bus_size(size), .i_bus_addr(addr), .i_bus_wdata(wdata),
    .i_bus_atomic(atomic), .i_bus_sc(sc),
    .o_bus_rdata(rd[1]), .o_bus_hit(hit[1]), .o_bus_err(err[1])
  );

  dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(B2), .LATENCY(5)) u_l5 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(en[2]), .i_bus_we(we),
    .i_bus_size(size), .i_bus_addr(addr), .i_bus_wdata(wdata),
    .i_bus_atomic(atomic), .i_bus_sc(sc),
    .o_bus_rdata(rd[2]), .o_bus_hit(hit[2]), .o_bus_err(err[2])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input string tag, input int d, input logic w,
                     input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic at,
                     input logic s, input logic [31:0] er,
                     input logic ee);
    exp_t e;
    int n;
    sb.push_back('{rdata: er, err: ee});
    @(negedge clk);
    we = w; size = sz; addr = a; wdata = wd;
    atomic = at; sc = s; en[d] = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!hit[d] && n < 40);
    en[d] = 1'b0;
    e = sb.pop_front();
    chk({tag, "_lat"}, n, lat(d));
    chk({tag, "_rdata"}, rd[d], e.rdata);
    chk({tag, "_err"}, 32'(err[d]), 32'(e.err));
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(hit[d]), 0);
  endtask

  task automatic ld(input string t, input int d, input logic [31:0] a,
                    input logic [31:0] er, input logic ee);
    req(t, d, 1'b0, 2'b10, a, 32'h0, 1'b0, 1'b0, er, ee);
  endtask

  task automatic st(input string t, input int d, input logic [1:0] sz,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic ee);
    req(t, d, 1'b1, sz, a, wd, 1'b0, 1'b0, 32'h0, ee);
  endtask

  task automatic lr(input string t, input logic [31:0] a,
                    input logic [31:0] er);
    req(t, 1, 1'b0, 2'b10, a, 32'h0, 1'b1, 1'b0, er, 1'b0);
  endtask

  task automatic scw(input string t, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er);
    req(t, 1, 1'b1, 2'b10, a, wd, 1'b1, 1'b1, er, 1'b0);
  endtask

  task automatic b2b(input string tag, input int d, input logic [31:0] a,
                     input logic [31:0] v);
    int n;
    @(negedge clk);
    we = 1'b0; size = 2'b10; addr = a; atomic = 1'b0; sc = 1'b0;
    en[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!hit[d] && n < 40);
    chk({tag, "_first"}, 32'(hit[d]), 1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!hit[d] && n < 40);
      chk({tag, "_period"}, n, lat(d) + 2);
      chk({tag, "_data"}, rd[d], v);
    end
    en[d] = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, 32'(hit[d]), 0);
  endtask

  initial begin
    int nh;
    rst = 1'b1; en = 3'b000; we = 1'b0; size = 2'b10;
    addr = '0; wdata = '0; atomic = 1'b0; sc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_hit", 32'(hit[d]), 0);
      chk("rst_err", 32'(err[d]), 0);
      chk("rst_rdata", rd[d], 0);
    end
    rst = 1'b0;

    st("w_st", 1, 2'b10, B1 + 8, 32'hDEAD_BEEF, 1'b0);
    ld("w_ld", 1, B1 + 8, 32'hDEAD_BEEF, 1'b0);
    b2b("b2b_l2", 1, B1 + 8, 32'hDEAD_BEEF);

    st("w0_clr", 1, 2'b10, B1, 32'h0, 1'b0);
    st("b_st", 1, 2'b00, B1 + 1, 32'hFFFF_FFAA, 1'b0);
    st("h_st", 1, 2'b01, B1 + 2, 32'hABCD_1234, 1'b0);
    ld("lanes", 1, B1, 32'h1234_AA00, 1'b0);

    ld("mis_w", 1, B1 + 2, 32'h0, 1'b1);
    st("mis_h", 1, 2'b01, B1 + 1, 32'hFFFF_FFFF, 1'b1);
    ld("reread1", 1, B1, 32'h1234_AA00, 1'b0);
    ld("oor_hi", 1, B1 + 32'h400, 32'h0, 1'b1);
    ld("oor_lo", 1, B1 - 4, 32'h0, 1'b1);
    req("sz11", 1, 1'b0, 2'b11, B1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    req("at_sz", 1, 1'b0, 2'b01, B1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    st("oor_st", 1, 2'b10, B1 + 32'h400, 32'h0000_0099, 1'b1);
    ld("reread2", 1, B1, 32'h1234_AA00, 1'b0);
    st("b3_st", 1, 2'b00, B1 + 3, 32'h0000_005A, 1'b0);
    st("h0_st", 1, 2'b01, B1, 32'h0000_BEEF, 1'b0);
    ld("lanes2", 1, B1, 32'h5A34_BEEF, 1'b0);

    st("pre16", 1, 2'b10, B1 + 16, 32'hCAFE_F00D, 1'b0);
    lr("lr1", B1 + 16, 32'hCAFE_F00D);
    scw("sc1", B1 + 16, 32'h55, 32'h0);
    ld("sc1_ld", 1, B1 + 16, 32'h55, 1'b0);
    scw("sc2", B1 + 16, 32'h66, 32'h1);
    ld("sc2_ld", 1, B1 + 16, 32'h55, 1'b0);

    lr("lr2", B1 + 16, 32'h55);
    st("st_oth", 1, 2'b10, B1 + 20, 32'h77, 1'b0);
    scw("sc3", B1 + 16, 32'h88, 32'h0);
    ld("sc3_ld", 1, B1 + 16, 32'h88, 1'b0);

    lr("lr3", B1 + 16, 32'h88);
    st("st_same", 1, 2'b10, B1 + 16, 32'h99, 1'b0);
    scw("sc4", B1 + 16, 32'hAA, 32'h1);
    ld("sc4_ld", 1, B1 + 16, 32'h99, 1'b0);

    lr("lr4", B1 + 16, 32'h99);
    scw("sc_idx", B1 + 20, 32'hBB, 32'h1);
    ld("sc_idx_ld", 1, B1 + 20, 32'h77, 1'b0);

    lr("lr5", B1 + 16, 32'h99);
    req("sc_bad", 1, 1'b1, 2'b01, B1 + 16, 32'hEE, 1'b1, 1'b1,
        32'h0, 1'b1);
    scw("sc5", B1 + 16, 32'hCC, 32'h0);
    ld("sc5_ld", 1, B1 + 16, 32'hCC, 1'b0);

    st("pre0", 1, 2'b10, B1, 32'h2222_2222, 1'b0);
    lr("lr6", B1 + 16, 32'hCC);
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = B1; wdata = 32'h1111_1111;
    atomic = 1'b0; sc = 1'b0; en[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; en[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstw_hit", 32'(hit[1]), 0);
    chk("rstw_rdata", rd[1], 0);
    nh = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (hit[1]) nh++;
    end
    chk("rstw_nohit", nh, 0);
    ld("rstw_ld", 1, B1, 32'h2222_2222, 1'b0);
    scw("rstw_sc", B1 + 16, 32'hDD, 32'h1);
    ld("rstw_ld16", 1, B1 + 16, 32'hCC, 1'b0);

    st("l1_st", 0, 2'b10, B0 + 8, 32'h1357_9BDF, 1'b0);
    ld("l1_ld", 0, B0 + 8, 32'h1357_9BDF, 1'b0);
    b2b("b2b_l1", 0, B0 + 8, 32'h1357_9BDF);
    ld("l1_oor", 0, B0 + 64, 32'h0, 1'b1);

    st("l5_st", 2, 2'b10, B2 + 32'h40, 32'h0BAD_F00D, 1'b0);
    ld("l5_ld", 2, B2 + 32'h40, 32'h0BAD_F00D, 1'b0);
    b2b("b2b_l5", 2, B2 + 32'h40, 32'h0BAD_F00D);
    ld("l5_oor", 2, B2 + 32'h100, 32'h0, 1'b1);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
